// File: rtl/partition_table_ctrl_if.sv
// Request/response channel between the instruction decoder and the partition table sequencer.
// The decoder is the master; the sequencer is the slave.
interface partition_table_ctrl_if #(
  parameter int MAX_MODULES = 64,
  parameter int MU_W        = 64
);
  localparam int IDX_W = $clog2(MAX_MODULES);

  logic             req_valid;
  logic             req_ready;
  logic             req_op;
  logic [7:0]       req_region;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [IDX_W-1:0] rsp_idx;
  logic             rsp_created;
  logic             rsp_full;
  logic [MU_W-1:0]  rsp_cost;

  modport master (
    output req_valid, req_op, req_region, rsp_ready,
    input  req_ready, rsp_valid, rsp_idx, rsp_created, rsp_full, rsp_cost
  );

  modport slave (
    input  req_valid, req_op, req_region, rsp_ready,
    output req_ready, rsp_valid, rsp_idx, rsp_created, rsp_full, rsp_cost
  );
endinterface

// File: rtl/partition_table_ctrl.sv
// Partition module table sequencer: deduplicating PNEW (scan + allocate) and
// FINALIZE execution charging, one request in flight.
module partition_table_ctrl #(
  parameter int MAX_MODULES = 64,
  parameter int MASK_W      = 64,
  parameter int ID_W        = 32,
  parameter int MU_W        = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  partition_table_ctrl_if.slave          bus,
  output logic                           cur_valid,
  output logic [$clog2(MAX_MODULES)-1:0] cur_idx,
  output logic [ID_W-1:0]                num_modules,
  output logic [ID_W-1:0]                next_id,
  output logic [MU_W-1:0]                mu_discovery,
  output logic [MU_W-1:0]                mu_execution
);
  localparam int IDX_W = $clog2(MAX_MODULES);
  localparam int CNT_W = IDX_W + 1;
  localparam int POP_W = $clog2(MASK_W + 1);
  localparam int HB_W  = $clog2(MASK_W);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_MODULES);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SCAN   = 3'd1;
  localparam logic [2:0] S_DECIDE = 3'd2;
  localparam logic [2:0] S_FIN    = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  // Charge = bit-length of the highest set bit times popcount; an empty mask costs 1.
  function automatic logic [MU_W-1:0] exec_cost(input logic [MASK_W-1:0] m);
    logic [POP_W-1:0] pop;
    logic [HB_W-1:0]  hb;
    logic [POP_W-1:0] bl;
    pop = '0;
    hb  = '0;
    bl  = POP_W'(1);
    for (int i = 0; i < MASK_W; i++) begin
      if (m[i]) begin
        pop = pop + POP_W'(1);
        hb  = HB_W'(i);
      end
    end
    for (int b = 0; b < HB_W; b++) begin
      if (hb[b]) bl = POP_W'(b + 1);
    end
    if (pop == '0) return MU_W'(1);
    return MU_W'(bl) * MU_W'(pop);
  endfunction

  logic [2:0]        state_q, state_d;
  logic [MASK_W-1:0] req_mask_q, req_mask_d;
  logic [IDX_W-1:0]  scan_idx_q, scan_idx_d;
  logic              match_vld_q, match_vld_d;
  logic [IDX_W-1:0]  match_idx_q, match_idx_d;
  logic [MASK_W-1:0] masks_q [MAX_MODULES];
  logic [MASK_W-1:0] masks_d [MAX_MODULES];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ID_W-1:0]   next_id_q, next_id_d;
  logic              cur_valid_q, cur_valid_d;
  logic [IDX_W-1:0]  cur_idx_q, cur_idx_d;
  logic [MU_W-1:0]   mu_disc_q, mu_disc_d;
  logic [MU_W-1:0]   mu_exec_q, mu_exec_d;
  logic [IDX_W-1:0]  rsp_idx_q, rsp_idx_d;
  logic              rsp_created_q, rsp_created_d;
  logic              rsp_full_q, rsp_full_d;
  logic [MU_W-1:0]   rsp_cost_q, rsp_cost_d;

  logic              scan_hit;
  logic              scan_last;
  logic              tbl_full;
  logic [MU_W-1:0]   fin_cost;

  // Module IDs are issued sequentially and never freed, so entry i always holds ID i.
  assign scan_hit  = (masks_q[scan_idx_q] == req_mask_q);
  assign scan_last = ({1'b0, scan_idx_q} == (cnt_q - CNT_ONE));
  assign tbl_full  = (cnt_q == CNT_FULL);
  assign fin_cost  = cur_valid_q ? exec_cost(masks_q[cur_idx_q]) : '0;

  always_comb begin
    // NOTE: every _d gets a default from its _q first, so no path leaves a
    // signal unassigned and no latch is inferred.
    state_d       = state_q;
    req_mask_d    = req_mask_q;
    scan_idx_d    = scan_idx_q;
    match_vld_d   = match_vld_q;
    match_idx_d   = match_idx_q;
    masks_d       = masks_q;
    cnt_d         = cnt_q;
    next_id_d     = next_id_q;
    cur_valid_d   = cur_valid_q;
    cur_idx_d     = cur_idx_q;
    mu_disc_d     = mu_disc_q;
    mu_exec_d     = mu_exec_q;
    rsp_idx_d     = rsp_idx_q;
    rsp_created_d = rsp_created_q;
    rsp_full_d    = rsp_full_q;
    rsp_cost_d    = rsp_cost_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          req_mask_d  = (32'(bus.req_region) < MASK_W) ? (MASK_W'(1) << bus.req_region) : '0;
          scan_idx_d  = '0;
          match_vld_d = 1'b0;
          match_idx_d = '0;
          if (bus.req_op)         state_d = S_FIN;
          else if (cnt_q == '0)   state_d = S_DECIDE;
          else                    state_d = S_SCAN;
        end
      end

      S_SCAN: begin
        // Later hits overwrite earlier ones: the last matching entry wins.
        if (scan_hit) begin
          match_vld_d = 1'b1;
          match_idx_d = scan_idx_q;
        end
        if (scan_last) state_d    = S_DECIDE;
        else           scan_idx_d = scan_idx_q + IDX_W'(1);
      end

      S_DECIDE: begin
        rsp_cost_d    = '0;
        rsp_created_d = 1'b0;
        rsp_full_d    = 1'b0;
        if (match_vld_q) begin
          cur_valid_d = 1'b1;
          cur_idx_d   = match_idx_q;
          rsp_idx_d   = match_idx_q;
        end else if (!tbl_full) begin
          masks_d[cnt_q[IDX_W-1:0]] = req_mask_q;
          cnt_d         = cnt_q + CNT_ONE;
          next_id_d     = next_id_q + ID_W'(1);
          cur_valid_d   = 1'b1;
          cur_idx_d     = cnt_q[IDX_W-1:0];
          mu_disc_d     = mu_disc_q + MU_W'(1);
          rsp_idx_d     = cnt_q[IDX_W-1:0];
          rsp_created_d = 1'b1;
        end else begin
          rsp_idx_d  = '0;
          rsp_full_d = 1'b1;
        end
        state_d = S_RESP;
      end

      S_FIN: begin
        mu_exec_d     = mu_exec_q + fin_cost;
        rsp_cost_d    = fin_cost;
        rsp_created_d = 1'b0;
        rsp_full_d    = 1'b0;
        state_d       = S_RESP;
      end

      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_created_d = 1'b0;
          rsp_full_d    = 1'b0;
          state_d       = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      req_mask_q    <= '0;
      scan_idx_q    <= '0;
      match_vld_q   <= 1'b0;
      match_idx_q   <= '0;
      cnt_q         <= '0;
      next_id_q     <= '0;
      cur_valid_q   <= 1'b0;
      cur_idx_q     <= '0;
      mu_disc_q     <= '0;
      mu_exec_q     <= '0;
      rsp_idx_q     <= '0;
      rsp_created_q <= 1'b0;
      rsp_full_q    <= 1'b0;
      rsp_cost_q    <= '0;
    end else begin
      state_q       <= state_d;
      req_mask_q    <= req_mask_d;
      scan_idx_q    <= scan_idx_d;
      match_vld_q   <= match_vld_d;
      match_idx_q   <= match_idx_d;
      cnt_q         <= cnt_d;
      next_id_q     <= next_id_d;
      cur_valid_q   <= cur_valid_d;
      cur_idx_q     <= cur_idx_d;
      mu_disc_q     <= mu_disc_d;
      mu_exec_q     <= mu_exec_d;
      rsp_idx_q     <= rsp_idx_d;
      rsp_created_q <= rsp_created_d;
      rsp_full_q    <= rsp_full_d;
      rsp_cost_q    <= rsp_cost_d;
    end
  end

  // NOTE: the mask table is reset like ordinary flops; a cleared table is part
  // of the architectural reset state, not just an optimisation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_MODULES; i++) masks_q[i] <= '0;
    end else begin
      masks_q <= masks_d;
    end
  end

  assign bus.req_ready   = (state_q == S_IDLE);
  assign bus.rsp_valid   = (state_q == S_RESP);
  assign bus.rsp_idx     = rsp_idx_q;
  assign bus.rsp_created = rsp_created_q;
  assign bus.rsp_full    = rsp_full_q;
  assign bus.rsp_cost    = rsp_cost_q;

  assign cur_valid    = cur_valid_q;
  assign cur_idx      = cur_idx_q;
  assign num_modules  = ID_W'(cnt_q);
  assign next_id      = next_id_q;
  assign mu_discovery = mu_disc_q;
  assign mu_execution = mu_exec_q;
endmodule

// File: tb/tb_partition_table_ctrl.sv
// Self-checking bench for partition_table_ctrl: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based reference model.
module tb_partition_table_ctrl;
  localparam int MAXM = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  partition_table_ctrl_if #(.MAX_MODULES(MAXM), .MU_W(64)) bus ();

  logic        cur_valid;
  logic [5:0]  cur_idx;
  logic [31:0] num_modules;
  logic [31:0] next_id;
  logic [63:0] mu_discovery;
  logic [63:0] mu_execution;

  partition_table_ctrl #(.MAX_MODULES(MAXM), .MASK_W(64), .ID_W(32), .MU_W(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .cur_valid   (cur_valid),
    .cur_idx     (cur_idx),
    .num_modules (num_modules),
    .next_id     (next_id),
    .mu_discovery(mu_discovery),
    .mu_execution(mu_execution)
  );

  typedef struct packed {
    logic [31:0] lat;
    logic [63:0] idx;
    logic        created;
    logic        full;
    logic [63:0] cost;
    logic [63:0] num;
    logic [63:0] nid;
    logic [63:0] disc;
    logic [63:0] exec;
    logic        cv;
    logic [63:0] ci;
  } obs_t;

  typedef struct {
    bit         op;
    logic [7:0] region;
    int         stall;
    obs_t       exp;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  logic [63:0] m_tbl[$];
  int          m_next;
  bit          m_cv;
  int          m_ci;
  logic [63:0] m_disc;
  logic [63:0] m_exec;

  task automatic model_reset();
    m_tbl.delete();
    m_next = 0;
    m_cv   = 0;
    m_ci   = 0;
    m_disc = '0;
    m_exec = '0;
  endtask

  task automatic model_step(input bit op, input logic [7:0] region, output obs_t e);
    logic [63:0] mask;
    logic [63:0] m;
    int n, hit, p, h, bl;
    logic [63:0] cost;
    e = '0;
    if (!op) begin
      mask = (region < 64) ? (64'd1 << region) : 64'd0;
      n    = m_tbl.size();
      hit  = -1;
      for (int i = 0; i < n; i++) if (m_tbl[i] == mask) hit = i;
      e.lat = 32'(n + 2);
      if (hit >= 0) begin
        m_cv  = 1;
        m_ci  = hit;
        e.idx = 64'(hit);
      end else if (n < MAXM) begin
        m_tbl.push_back(mask);
        m_next++;
        m_cv      = 1;
        m_ci      = n;
        m_disc    = m_disc + 64'd1;
        e.idx     = 64'(n);
        e.created = 1'b1;
      end else begin
        e.full = 1'b1;
        e.idx  = '0;
      end
    end else begin
      e.lat = 32'd2;
      cost  = '0;
      if (m_cv) begin
        m = m_tbl[m_ci];
        p = $countones(m);
        if (p == 0) cost = 64'd1;
        else begin
          h = 0;
          for (int b = 0; b < 64; b++) if (m[b]) h = b;
          bl   = (h == 0) ? 1 : $clog2(h + 1);
          cost = 64'(bl * p);
        end
      end
      m_exec = m_exec + cost;
      e.cost = cost;
    end
    e.num  = 64'(m_tbl.size());
    e.nid  = 64'(m_next);
    e.disc = m_disc;
    e.exec = m_exec;
    e.cv   = m_cv;
    e.ci   = 64'(m_ci);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic issue(input bit op, input logic [7:0] region, input int stall, output obs_t o);
    int cyc;
    bit seen;
    o = '0;
    @(negedge clk);
    check("req_ready_idle", 64'(bus.req_ready), 64'd1);
    bus.req_valid  = 1'b1;
    bus.req_op     = op;
    bus.req_region = region;
    bus.rsp_ready  = (stall == 0);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (bus.rsp_valid) seen = 1;
    end
    check("rsp_arrived", 64'(seen), 64'd1);
    o.lat     = 32'(cyc);
    o.idx     = 64'(bus.rsp_idx);
    o.created = bus.rsp_created;
    o.full    = bus.rsp_full;
    o.cost    = bus.rsp_cost;
    o.num     = 64'(num_modules);
    o.nid     = 64'(next_id);
    o.disc    = mu_discovery;
    o.exec    = mu_execution;
    o.cv      = cur_valid;
    o.ci      = 64'(cur_idx);
    if (stall > 0) repeat (stall) @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string tag, input obs_t a, input obs_t e, input bit op);
    check({tag, ".lat"}, 64'(a.lat), 64'(e.lat));
    if (!op) begin
      check({tag, ".rsp_idx"}, a.idx, e.idx);
      check({tag, ".created"}, 64'(a.created), 64'(e.created));
      check({tag, ".full"}, 64'(a.full), 64'(e.full));
    end else begin
      check({tag, ".cost"}, a.cost, e.cost);
    end
    check({tag, ".num_modules"}, a.num, e.num);
    check({tag, ".next_id"}, a.nid, e.nid);
    check({tag, ".mu_discovery"}, a.disc, e.disc);
    check({tag, ".mu_execution"}, a.exec, e.exec);
    check({tag, ".cur_valid"}, 64'(a.cv), 64'(e.cv));
    check({tag, ".cur_idx"}, a.ci, e.ci);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".req_ready"}, 64'(bus.req_ready), 64'd1);
    check({tag, ".rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
    check({tag, ".cur_valid"}, 64'(cur_valid), 64'd0);
    check({tag, ".cur_idx"}, 64'(cur_idx), 64'd0);
    check({tag, ".num_modules"}, 64'(num_modules), 64'd0);
    check({tag, ".next_id"}, 64'(next_id), 64'd0);
    check({tag, ".mu_discovery"}, mu_discovery, 64'd0);
    check({tag, ".mu_execution"}, mu_execution, 64'd0);
  endtask

  function automatic vec_t mk(input bit op, input logic [7:0] region, input int stall,
                              input int lat, input int idx, input bit cr, input int cost,
                              input int num, input int disc, input int exec,
                              input bit cv, input int ci);
    vec_t v;
    v.op          = op;
    v.region      = region;
    v.stall       = stall;
    v.exp         = '0;
    v.exp.lat     = 32'(lat);
    v.exp.idx     = 64'(idx);
    v.exp.created = cr;
    v.exp.cost    = 64'(cost);
    v.exp.num     = 64'(num);
    v.exp.nid     = 64'(num);
    v.exp.disc    = 64'(disc);
    v.exp.exec    = 64'(exec);
    v.exp.cv      = cv;
    v.exp.ci      = 64'(ci);
    return v;
  endfunction

  localparam int NV = 13;
  vec_t vecs [NV];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t o, e;
    bit   seen;
    int   cyc;
    bit   op;
    logic [7:0] region;

    // op, region, stall, lat, idx, created, cost, num, disc, exec, cur_valid, cur_idx
    vecs[0]  = mk(1, 8'd0,   0, 2, 0, 0, 0, 0, 0, 0,  0, 0);
    vecs[1]  = mk(0, 8'd3,   0, 2, 0, 1, 0, 1, 1, 0,  1, 0);
    vecs[2]  = mk(0, 8'd5,   1, 3, 1, 1, 0, 2, 2, 0,  1, 1);
    vecs[3]  = mk(1, 8'd0,   0, 2, 0, 0, 3, 2, 2, 3,  1, 1);
    vecs[4]  = mk(0, 8'd3,   2, 4, 0, 0, 0, 2, 2, 3,  1, 0);
    vecs[5]  = mk(1, 8'd0,   0, 2, 0, 0, 2, 2, 2, 5,  1, 0);
    vecs[6]  = mk(0, 8'd200, 0, 4, 2, 1, 0, 3, 3, 5,  1, 2);
    vecs[7]  = mk(1, 8'd0,   3, 2, 0, 0, 1, 3, 3, 6,  1, 2);
    vecs[8]  = mk(0, 8'd64,  0, 5, 2, 0, 0, 3, 3, 6,  1, 2);
    vecs[9]  = mk(0, 8'd0,   0, 5, 3, 1, 0, 4, 4, 6,  1, 3);
    vecs[10] = mk(1, 8'd0,   0, 2, 0, 0, 1, 4, 4, 7,  1, 3);
    vecs[11] = mk(0, 8'd63,  0, 6, 4, 1, 0, 5, 5, 7,  1, 4);
    vecs[12] = mk(1, 8'd0,   0, 2, 0, 0, 6, 5, 5, 13, 1, 4);

    bus.req_valid  = 1'b0;
    bus.req_op     = 1'b0;
    bus.req_region = '0;
    bus.rsp_ready  = 1'b1;
    model_reset();

    // Reset state, then idle after release.
    @(negedge clk);
    check_idle_outputs("reset");
    check("reset.rsp_created", 64'(bus.rsp_created), 64'd0);
    check("reset.rsp_full", 64'(bus.rsp_full), 64'd0);
    check("reset.rsp_cost", bus.rsp_cost, 64'd0);
    check("reset.rsp_idx", 64'(bus.rsp_idx), 64'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_idle_outputs("idle5");

    // Directed vector table.
    for (int i = 0; i < NV; i++) begin
      issue(vecs[i].op, vecs[i].region, vecs[i].stall, o);
      cmp($sformatf("vec%0d", i), o, vecs[i].exp, vecs[i].op);
    end

    // Back-pressure: region 5 lives at index 1, table holds 5 entries.
    @(negedge clk);
    bus.rsp_ready  = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_op     = 1'b0;
    bus.req_region = 8'd5;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.rsp_valid) seen = 1;
    end
    check("bp.rsp_arrived", 64'(seen), 64'd1);
    check("bp.lat", 64'(cyc), 64'd7);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp.rsp_valid_held", 64'(bus.rsp_valid), 64'd1);
      check("bp.rsp_idx_held", 64'(bus.rsp_idx), 64'd1);
      check("bp.created_held", 64'(bus.rsp_created), 64'd0);
      check("bp.req_ready_low", 64'(bus.req_ready), 64'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp.rsp_valid_after", 64'(bus.rsp_valid), 64'd0);
    check("bp.req_ready_after", 64'(bus.req_ready), 64'd1);

    // Asynchronous reset in the middle of a scan.
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_op     = 1'b0;
    bus.req_region = 8'd7;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midscan_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("midscan_rst.no_rsp", 64'(bus.rsp_valid), 64'd0);
    end
    check("midscan_rst.num_modules", 64'(num_modules), 64'd0);

    // Fill the table, then a zero-mask PNEW must report full.
    for (int r = 0; r < MAXM; r++) begin
      model_step(0, 8'(r), e);
      issue(0, 8'(r), 0, o);
      cmp($sformatf("fill%0d", r), o, e, 1'b0);
    end
    model_step(0, 8'd64, e);
    issue(0, 8'd64, 0, o);
    cmp("full", o, e, 1'b0);
    check("full.rsp_full", 64'(o.full), 64'd1);
    check("full.created", 64'(o.created), 64'd0);
    check("full.rsp_idx", o.idx, 64'd0);
    check("full.num_modules", o.num, 64'd64);
    check("full.mu_discovery", o.disc, 64'd64);
    check("full.cur_idx", o.ci, 64'd63);
    model_step(1, 8'd0, e);
    issue(1, 8'd0, 0, o);
    cmp("full_fin", o, e, 1'b1);
    check("full_fin.cost", o.cost, 64'd6);

    // Randomized traffic against the reference model.
    do_reset();
    for (int t = 0; t < 150; t++) begin
      op = ($urandom_range(0, 3) == 0);
      region = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(60, 255)) : 8'($urandom_range(0, 15));
      model_step(op, region, e);
      issue(op, region, int'($urandom_range(0, 3)), o);
      cmp($sformatf("rnd%0d", t), o, e, op);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
